// File: rtl/cycle_bus_arbiter.sv
// rtl/cycle_bus_arbiter.sv - round-robin burst arbiter for a shared tristate bus segment
module cycle_bus_arbiter #(
    parameter int W         = 8,
    parameter int N         = 4,
    parameter int TURN      = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     last,
    input  logic [N*W-1:0]   wdata,
    output logic [N-1:0]     accept,
    output logic [N-1:0]     grant,
    output logic             busy,
    output logic [W-1:0]     X_out,
    output logic [W-1:0]     X_drive,
    input  logic [W-1:0]     X_in,
    output logic [W-1:0]     rdata
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
    localparam logic [3:0]    TURN_LAST = (TURN > 0) ? 4'(TURN - 1) : 4'd0;
    localparam logic [N-1:0]  ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IW:0]   N_EXT     = (IW+1)'(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick;
    logic            pick_valid;
    logic [IW-1:0]   owner_next_rr;
    logic [BW-1:0]   beat;
    logic [3:0]      turn_cnt;
    logic            own_req;
    logic            own_last;
    logic [W-1:0]    own_data;
    logic            drive_now;
    logic            drive_exit;
    logic            turn_done;
    logic [IW:0]     rr_sum;

    // Select the current owner's request, last flag and data; everyone else is ignored
    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int i = 0; i < N; i++) begin
            if (owner == IW'(i)) begin
                own_req  = req[i];
                own_last = last[i];
                own_data = wdata[i*W +: W];
            end
        end
    end

    // Round-robin pick: first set request at or after the pointer, wrapping N-1 -> 0
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        rr_sum     = '0;
        for (int k = 0; k < N; k++) begin
            rr_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (rr_sum >= N_EXT) begin
                rr_sum = rr_sum - N_EXT;
            end
            if (!pick_valid && req[rr_sum[IW-1:0]]) begin
                pick       = rr_sum[IW-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    assign owner_next_rr = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
    assign drive_exit    = !own_req || own_last || (beat == BEAT_LAST);
    assign turn_done     = (turn_cnt == TURN_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> DRIVE on any request, DRIVE -> TURN/IDLE on exit, TURN counts out
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (drive_exit) begin
                    state_next = (TURN > 0) ? ST_TURN : ST_IDLE;
                end
            end
            ST_TURN: begin
                if (turn_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: drive the bus only during a DRIVE cycle in which the owner presents a beat
    always_comb begin
        busy      = (state != ST_IDLE);
        drive_now = (state == ST_DRIVE) && own_req;
        X_drive   = {W{drive_now}};
        X_out     = drive_now ? own_data : '0;
        accept    = drive_now ? (ONE_HOT0 << owner) : '0;
    end

    // Owner, grant, round-robin pointer and beat/turn counters
    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= '0;
            grant    <= '0;
            rr_ptr   <= '0;
            beat     <= '0;
            turn_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    turn_cnt <= '0;
                    if (pick_valid) begin
                        owner <= pick;
                        grant <= ONE_HOT0 << pick;
                        beat  <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (drive_exit) begin
                        rr_ptr   <= owner_next_rr;
                        grant    <= '0;
                        beat     <= '0;
                        turn_cnt <= '0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                ST_TURN: begin
                    if (turn_done) begin
                        turn_cnt <= '0;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

    // Resolved bus value is registered every cycle, independent of arbitration state
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= X_in;
        end
    end

endmodule

// File: tb/tb_cycle_bus_arbiter.sv
// tb/tb_cycle_bus_arbiter.sv - directed self-checking bench for cycle_bus_arbiter
module tb_cycle_bus_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   accept;
    logic [N-1:0]   grant;
    logic           busy;
    logic [W-1:0]   X_out;
    logic [W-1:0]   X_drive;
    logic [W-1:0]   X_in;
    logic [W-1:0]   rdata;

    int checks = 0;
    int errors = 0;

    cycle_bus_arbiter #(.W(W), .N(N), .TURN(1), .MAX_BURST(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .last    (last),
        .wdata   (wdata),
        .accept  (accept),
        .grant   (grant),
        .busy    (busy),
        .X_out   (X_out),
        .X_drive (X_drive),
        .X_in    (X_in),
        .rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        wdata[i*W +: W] = v;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        last  = '0;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        last  = '0;
        wdata = '0;
        X_in  = 8'h77;
        step();
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || X_drive !== 8'h00 || accept !== 4'b0000 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: grant=%b busy=%b X_drive=%h accept=%b rdata=%h, required 0000 0 00 0000 00",
                     grant, busy, X_drive, accept, rdata);
        end
        reset = 1'b0;
        X_in  = 8'h00;
        #1;
    endtask

    task automatic test_single_burst();
        logic [W-1:0] exp_data [3];
        exp_data[0] = 8'hAA;
        exp_data[1] = 8'hBB;
        exp_data[2] = 8'hCC;
        do_reset();
        req = 4'b0001;
        set_data(0, 8'hAA);
        checks++;
        if (X_drive !== 8'h00 || accept !== 4'b0000) begin
            errors++;
            $display("FAIL burst_idle_cycle0: X_drive=%h accept=%b, required 00 0000", X_drive, accept);
        end
        for (int b = 0; b < 3; b++) begin
            step();
            last = (b == 2) ? 4'b0001 : 4'b0000;
            set_data(0, exp_data[b]);
            checks++;
            if (grant !== 4'b0001 || X_drive !== 8'hFF || X_out !== exp_data[b] || accept !== 4'b0001) begin
                errors++;
                $display("FAIL burst_beat%0d: grant=%b X_drive=%h X_out=%h accept=%b, required 0001 FF %h 0001",
                         b, grant, X_drive, X_out, accept, exp_data[b]);
            end
        end
        step();
        req  = '0;
        last = '0;
        #1;
        checks++;
        if (X_drive !== 8'h00 || grant !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL burst_turn_cycle4: X_drive=%h grant=%b busy=%b, required 00 0000 1", X_drive, grant, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_idle_cycle5: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 8'hD0 + 8'(i));
        req  = 4'b1111;
        last = 4'b1111;
        #1;
        for (int b = 0; b < 5; b++) begin
            step();
            checks++;
            if (grant !== (4'b0001 << (b % 4)) || X_drive !== 8'hFF || X_out !== (8'hD0 + 8'(b % 4))) begin
                errors++;
                $display("FAIL rr_burst%0d: grant=%b X_drive=%h X_out=%h, required %b FF %h",
                         b, grant, X_drive, X_out, 4'b0001 << (b % 4), 8'hD0 + 8'(b % 4));
            end
            for (int g = 0; g < 2; g++) begin
                step();
                checks++;
                if (X_drive !== 8'h00 || accept !== 4'b0000) begin
                    errors++;
                    $display("FAIL rr_gap%0d_%0d: X_drive=%h accept=%b, required 00 0000", b, g, X_drive, accept);
                end
            end
        end
        req  = '0;
        last = '0;
        #1;
    endtask

    task automatic test_max_burst();
        int pulses;
        pulses = 0;
        do_reset();
        req  = 4'b0110;
        last = 4'b0000;
        #1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (accept[1]) pulses++;
            checks++;
            if (accept[0] || accept[3] || (accept[2] && c < 7)) begin
                errors++;
                $display("FAIL max_accept_owner_c%0d: accept=%b, required only bit1 or none", c, accept);
            end
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL max_burst_pulses: got %0d accept[1] pulses, required 4", pulses);
        end
        step();
        checks++;
        if (grant !== 4'b0100 || accept !== 4'b0100) begin
            errors++;
            $display("FAIL max_next_grant: grant=%b accept=%b, required 0100 0100", grant, accept);
        end
        req = '0;
        #1;
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b1000;
        set_data(3, 8'h5E);
        step();
        step();
        checks++;
        if (accept !== 4'b1000 || X_drive !== 8'hFF) begin
            errors++;
            $display("FAIL drop_beat2: accept=%b X_drive=%h, required 1000 FF", accept, X_drive);
        end
        step();
        req = 4'b0000;
        #1;
        checks++;
        if (X_drive !== 8'h00 || accept !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_cycle: X_drive=%h accept=%b busy=%b, required 00 0000 1", X_drive, accept, busy);
        end
        step();
        checks++;
        if (busy !== 1'b1 || grant !== 4'b0000 || X_drive !== 8'h00) begin
            errors++;
            $display("FAIL drop_turn: busy=%b grant=%b X_drive=%h, required 1 0000 00", busy, grant, X_drive);
        end
        step();
        req = 4'b1111;
        #1;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL drop_rr_wrap: grant=%b, required 0001", grant);
        end
        req = '0;
        #1;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req  = 4'b0110;
        last = 4'b0000;
        X_in = 8'h5A;
        #1;
        step();
        step();
        reset = 1'b1;
        #1;
        step();
        checks++;
        if (grant !== 4'b0000 || X_drive !== 8'h00 || rdata !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset: grant=%b X_drive=%h rdata=%h busy=%b, required 0000 00 00 0",
                     grant, X_drive, rdata, busy);
        end
        reset = 1'b0;
        #1;
        step();
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_regrant: grant=%b, required 0010", grant);
        end
        req  = '0;
        X_in = 8'h00;
        #1;
    endtask

    task automatic test_rdata();
        do_reset();
        X_in = 8'hA5;
        #1;
        step();
        checks++;
        if (rdata !== 8'hA5) begin
            errors++;
            $display("FAIL rdata_idle: rdata=%h, required A5", rdata);
        end
        req = 4'b0001;
        set_data(0, 8'h11);
        step();
        X_in = 8'hC3;
        #1;
        checks++;
        if (busy !== 1'b1 || X_drive !== 8'hFF) begin
            errors++;
            $display("FAIL rdata_in_drive: busy=%b X_drive=%h, required 1 FF", busy, X_drive);
        end
        step();
        checks++;
        if (rdata !== 8'hC3) begin
            errors++;
            $display("FAIL rdata_drive: rdata=%h, required C3", rdata);
        end
        req = '0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        last  = '0;
        wdata = '0;
        X_in  = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_burst();
        test_drop();
        test_reset_mid_burst();
        test_rdata();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
